// File: rtl/ucaspian_syn_pkg.sv
// ucaspian_syn_pkg
//   Shared types and default sizes for the synapse walker slice.
//   syn_entry_t is the 16-bit synapse RAM word: [15:8] signed weight,
//   [7:0] target neuron id.
package ucaspian_syn_pkg;

  localparam int SYN_ADDR_W_DEFAULT = 12;
  localparam int NEURON_W_DEFAULT   = 8;
  localparam int WEIGHT_W_DEFAULT   = 8;

  typedef struct packed {
    logic signed [7:0] weight;
    logic        [7:0] target;
  } syn_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2
  } walk_state_t;

endpackage

// File: rtl/ucaspian_syn_outbuf.sv
// ucaspian_syn_outbuf
//   Two-entry valid/ready buffer holding synapse events on their way to the
//   dendrite stage. Entry 0 is always the head and drives the outputs
//   directly from flops, so data holds while out_vld && !out_rdy.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           drop both entries on the next edge
//   push/push_data  capture one entry (the caller guarantees free space)
//   out_rdy/out_vld/out_data  downstream handshake
//   occupancy       number of valid entries (0..2)
module ucaspian_syn_outbuf
  import ucaspian_syn_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  syn_entry_t push_data,
  input  logic       out_rdy,
  output logic       out_vld,
  output syn_entry_t out_data,
  output logic [1:0] occupancy
);

  logic       vld0_q, vld0_d, vld1_q, vld1_d;
  syn_entry_t ent0_q, ent0_d, ent1_q, ent1_d;
  logic       pop;

  assign pop = vld0_q && out_rdy;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (flush) begin
      vld0_d = 1'b0;
      vld1_d = 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Occupancy is unchanged; the new entry joins behind the survivor.
          if (vld1_q) begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end else begin
            ent0_d = push_data;
          end
        end
        2'b01: begin
          ent0_d = ent1_q;
          vld0_d = vld1_q;
          vld1_d = 1'b0;
        end
        2'b10: begin
          if (!vld0_q) begin
            ent0_d = push_data;
            vld0_d = 1'b1;
          end else begin
            ent1_d = push_data;
            vld1_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking
    // assignments so every flop samples the pre-edge values.
    if (reset) begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
    end
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

  assign out_vld   = vld0_q;
  assign out_data  = ent0_q;
  assign occupancy = 2'(vld0_q) + 2'(vld1_q);

endmodule

// File: rtl/ucaspian_syn_walker.sv
// ucaspian_syn_walker
//   Accepts one synapse range {syn_start, syn_end} (end exclusive, modular)
//   per handshake, reads every synapse in it from the local config RAM at
//   one read per cycle, and emits {target, weight} events downstream.
//   Also owns the RAM clear sweep and the idle indication.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   clear_act                   abort walk, flush events
//   clear_config / clear_done   level-held RAM sweep and its completion
//   config_*                    byte-wise synapse config write port
//   syn_start/syn_end/syn_vld/syn_rdy     range input handshake
//   dend_addr/dend_weight/dend_vld/dend_rdy  event output handshake
//   idle                        nothing active, in flight or buffered
// Build option:
//   SYN_SKIP_ZERO_EN  drop zero-weight entries at buffer capture.
module ucaspian_syn_walker
  import ucaspian_syn_pkg::*;
#(
  parameter int SYN_ADDR_W = SYN_ADDR_W_DEFAULT,
  parameter int NEURON_W   = NEURON_W_DEFAULT,
  parameter int WEIGHT_W   = WEIGHT_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_act,
  input  logic                       clear_config,
  output logic                       clear_done,
  input  logic [SYN_ADDR_W-1:0]      config_addr,
  input  logic [7:0]                 config_value,
  input  logic                       config_byte,
  input  logic                       config_enable,
  input  logic [SYN_ADDR_W-1:0]      syn_start,
  input  logic [SYN_ADDR_W-1:0]      syn_end,
  input  logic                       syn_vld,
  output logic                       syn_rdy,
  output logic [NEURON_W-1:0]        dend_addr,
  output logic signed [WEIGHT_W-1:0] dend_weight,
  output logic                       dend_vld,
  input  logic                       dend_rdy,
  output logic                       idle
);

  localparam int DEPTH = 2 ** SYN_ADDR_W;

  walk_state_t           state_q, state_d;
  logic [SYN_ADDR_W-1:0] ptr_q, ptr_d, end_q, end_d, ptr_inc;
  logic [SYN_ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic                  clear_done_q, clear_done_d;
  logic                  inflight_q;
  logic [7:0]            wlatch_q, wlatch_d;

  logic                  flush, hs, issue, credit_ok, push, pop;
  logic                  clr_we, cfg_we, ram_we;
  logic [SYN_ADDR_W-1:0] ram_waddr;
  syn_entry_t            ram_wdata, rdata_q, buf_data;
  logic [1:0]            occ;
  logic [2:0]            pending;

  syn_entry_t            mem [DEPTH];

  assign flush   = clear_act || clear_config;
  assign syn_rdy = !reset && (state_q == IDLE) && !clear_config && !clear_act;
  assign hs      = syn_vld && syn_rdy;
  assign pop     = dend_vld && dend_rdy;
  assign ptr_inc = ptr_q + SYN_ADDR_W'(1);

  // A read issued now lands in the buffer two edges later. Counting this
  // cycle's pop as already gone keeps one event per cycle flowing while
  // still never exceeding the two buffer slots.
  assign pending   = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign credit_ok = pending < 3'd2;
  assign issue     = (state_q == WALK) && (ptr_q != end_q) && !flush && credit_ok;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = WALK;
        ptr_d   = syn_start;
        end_d   = syn_end;
      end
      WALK: begin
        if (ptr_q == end_q) begin
          state_d = IDLE;
        end else if (issue) begin
          ptr_d = ptr_inc;
          if (ptr_inc == end_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_act)    state_d = IDLE;
    if (clear_config) state_d = CLEAR;
  end

  // Clear sweep: one zero write per cycle while in CLEAR, stopping after the
  // top address; everything re-arms when clear_config drops.
  always_comb begin
    clr_addr_d   = clr_addr_q;
    clear_done_d = clear_done_q;
    clr_we       = 1'b0;
    if (!clear_config) begin
      clr_addr_d   = '0;
      clear_done_d = 1'b0;
    end else if ((state_q == CLEAR) && !clear_done_q) begin
      clr_we     = 1'b1;
      clr_addr_d = clr_addr_q + SYN_ADDR_W'(1);
      if (clr_addr_q == '1) clear_done_d = 1'b1;
    end
  end

  assign cfg_we    = config_enable && config_byte && !clear_config;
  assign wlatch_d  = (config_enable && !config_byte && !clear_config) ? config_value : wlatch_q;
  assign ram_we    = clr_we || cfg_we;
  assign ram_waddr = clr_we ? clr_addr_q : config_addr;
  assign ram_wdata = clr_we ? '0 : syn_entry_t'({wlatch_q, config_value});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      end_q        <= '0;
      inflight_q   <= 1'b0;
      clr_addr_q   <= '0;
      clear_done_q <= 1'b0;
      wlatch_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      end_q        <= end_d;
      inflight_q   <= issue;
      clr_addr_q   <= clr_addr_d;
      clear_done_q <= clear_done_d;
      wlatch_q     <= wlatch_d;
    end
  end

  // NOTE: the RAM array and its read register carry no reset; contents are
  // only defined by config writes or the clear sweep.
  // A same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (issue)  rdata_q <= mem[ptr_q];
  end

`ifdef SYN_SKIP_ZERO_EN
  assign push = inflight_q && !flush && (rdata_q.weight != 8'sd0);
`else
  assign push = inflight_q && !flush;
`endif

  ucaspian_syn_outbuf u_outbuf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (rdata_q),
    .out_rdy   (dend_rdy),
    .out_vld   (dend_vld),
    .out_data  (buf_data),
    .occupancy (occ)
  );

  assign dend_addr   = NEURON_W'(buf_data.target);
  assign dend_weight = WEIGHT_W'(buf_data.weight);
  assign clear_done  = clear_done_q && clear_config;
  assign idle        = !reset && (state_q == IDLE) && !inflight_q && (occ == 2'd0) && !clear_config;

endmodule

// File: tb/tb_ucaspian_syn_walker.sv
// tb_ucaspian_syn_walker
//   Directed and randomized bench for ucaspian_syn_walker. The reference
//   model is a plain array of synapse words; expected event lists are built
//   from the range arithmetic and compared with what the monitor collects.
module tb_ucaspian_syn_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_act, clear_config, clear_done;
  logic [11:0] config_addr;
  logic [7:0]  config_value;
  logic        config_byte, config_enable;
  logic [11:0] syn_start, syn_end;
  logic        syn_vld, syn_rdy;
  logic [7:0]  dend_addr, dend_weight;
  logic        dend_vld, dend_rdy, idle;

  ucaspian_syn_walker dut (
    .clk           (clk),
    .reset         (reset),
    .clear_act     (clear_act),
    .clear_config  (clear_config),
    .clear_done    (clear_done),
    .config_addr   (config_addr),
    .config_value  (config_value),
    .config_byte   (config_byte),
    .config_enable (config_enable),
    .syn_start     (syn_start),
    .syn_end       (syn_end),
    .syn_vld       (syn_vld),
    .syn_rdy       (syn_rdy),
    .dend_addr     (dend_addr),
    .dend_weight   (dend_weight),
    .dend_vld      (dend_vld),
    .dend_rdy      (dend_rdy),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mdl [4096];            // {weight, target} as configured
  logic [15:0] exp_q[$], got_q[$];    // events as {target, weight}
  int          got_cyc[$];
  int          n_cmp = 0, n_fail = 0;
  int          rdy_mode = 0, rdy_k = 0;
  bit          stable_en = 1'b1;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_ev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    rdy_k++;
    case (rdy_mode)
      0:       dend_rdy = 1'b1;
      1:       dend_rdy = (rdy_k % 3 == 0);
      default: dend_rdy = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic write_syn(input logic [11:0] a, input logic [7:0] w, input logic [7:0] t);
    config_addr   = a;
    config_enable = 1'b1;
    config_byte   = 1'b0;
    config_value  = w;
    tick();
    config_byte   = 1'b1;
    config_value  = t;
    tick();
    config_enable = 1'b0;
    mdl[a] = {w, t};
  endtask

  // Build the expected event list and perform the range handshake.
  task automatic start_range(input logic [11:0] s, input logic [11:0] e, output int hs);
    logic [11:0] cnt;
    logic [15:0] ent;
    bit          keep;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    cnt = e - s;
    for (int i = 0; i < int'(cnt); i++) begin
      ent  = mdl[(int'(s) + i) % 4096];
      keep = 1'b1;
`ifdef SYN_SKIP_ZERO_EN
      keep = (ent[15:8] != 8'd0);
`endif
      if (keep) exp_q.push_back({ent[7:0], ent[15:8]});
    end
    syn_start = s;
    syn_end   = e;
    syn_vld   = 1'b1;
    hs        = -1;
    for (int k = 0; k < 50; k++) begin
      if (syn_rdy === 1'b1) begin
        hs = cyc + 1;
        tick();
        break;
      end
      tick();
    end
    syn_vld = 1'b0;
    check("handshake", 32'(hs >= 0), 32'd1);
  endtask

  task automatic finish_range(input string tag, input int budget);
    bit done = 1'b0;
    int n;
    for (int k = 0; k < budget; k++) begin
      if (idle === 1'b1 && got_q.size() >= exp_q.size()) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_ev%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // Monitor: collect accepted events and verify hold-while-stalled.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (stable_en && prev_stall)
        check("hold", {15'd0, dend_vld, dend_addr, dend_weight}, {15'd0, 1'b1, prev_ev});
      prev_stall = stable_en && dend_vld && !dend_rdy;
      prev_ev    = {dend_addr, dend_weight};
      if (dend_vld && dend_rdy) begin
        got_q.push_back({dend_addr, dend_weight});
        got_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int          hs;
    logic [11:0] s;
    int          len;

    reset         = 1'b1;
    clear_act     = 1'b0;
    clear_config  = 1'b0;
    config_addr   = '0;
    config_value  = '0;
    config_byte   = 1'b0;
    config_enable = 1'b0;
    syn_start     = '0;
    syn_end       = '0;
    syn_vld       = 1'b0;
    dend_rdy      = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_syn_rdy", 32'(syn_rdy), 32'd0);
    check("rst_dend_vld", 32'(dend_vld), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_idle", 32'(idle), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_syn_rdy", 32'(syn_rdy), 32'd1);

    // Full RAM sweep: 4096 writes, clear_done after the last one.
    clear_config = 1'b1;
    tick();
    check("clr_idle_low", 32'(idle), 32'd0);
    check("clr_syn_rdy_low", 32'(syn_rdy), 32'd0);
    repeat (4095) tick();
    check("clr_done_early", 32'(clear_done), 32'd0);
    tick();
    check("clr_done_set", 32'(clear_done), 32'd1);
    clear_config = 1'b0;
    #1;
    check("clr_done_drop", 32'(clear_done), 32'd0);
    for (int i = 0; i < 4096; i++) mdl[i] = 16'd0;
    tick();
    start_range(12'd0, 12'd8, hs);
    finish_range("zero", 100);

    // Basic three-synapse range at full rate.
    write_syn(12'd10, 8'd5, 8'd3);
    write_syn(12'd11, 8'hFE, 8'd7);
    write_syn(12'd12, 8'd1, 8'd0);
    start_range(12'd10, 12'd13, hs);
    finish_range("basic", 50);
    for (int i = 0; i < got_cyc.size() && i < 3; i++)
      check($sformatf("basic_cyc%0d", i), 32'(got_cyc[i]), 32'(hs + 2 + i));

    // Same range under periodic backpressure.
    rdy_mode = 1;
    rdy_k    = -1;
    start_range(12'd10, 12'd13, hs);
    finish_range("stall", 100);
    rdy_mode = 0;
    tick();

    // Empty range.
    start_range(12'd20, 12'd20, hs);
    check("empty_rdy_low", 32'(syn_rdy), 32'd0);
    tick();
    check("empty_rdy_back", 32'(syn_rdy), 32'd1);
    finish_range("empty", 20);

    // Range wrapping through the top address.
    write_syn(12'd4094, 8'd9, 8'h11);
    write_syn(12'd4095, 8'hF9, 8'h22);
    write_syn(12'd0, 8'h40, 8'h33);
    write_syn(12'd1, 8'h01, 8'h44);
    write_syn(12'd2, 8'h55, 8'h66);
    rdy_mode = 2;
    start_range(12'd4094, 12'd2, hs);
    finish_range("wrap", 100);
    rdy_mode = 0;
    tick();

    // Random synapse region, some zero weights.
    for (int a = 300; a < 400; a++)
      write_syn(12'(a), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                8'($urandom));

    // Abort a 100-synapse walk two cycles in.
    stable_en = 1'b0;
    start_range(12'd300, 12'd400, hs);
    tick();
    tick();
    clear_act = 1'b1;
    tick();
    clear_act = 1'b0;
    #1;
    check("abort_vld", 32'(dend_vld), 32'd0);
    check("abort_idle", 32'(idle), 32'd1);
    check("abort_syn_rdy", 32'(syn_rdy), 32'd1);
    stable_en = 1'b1;
    tick();
    start_range(12'd310, 12'd330, hs);
    finish_range("after_abort", 100);

    // Randomized ranges with random backpressure.
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      s   = 12'(300 + $urandom_range(0, 79));
      len = $urandom_range(0, 20);
      start_range(s, 12'(int'(s) + len), hs);
      finish_range($sformatf("rand%0d", r), 300);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ucaspian_syn_walker.md
Name: ucaspian_syn_walker

Overview:
- Consumer end of the axon->synapse range interface. It accepts one synapse range {syn_start, syn_end} per handshake.
- It walks every synapse address in the range through a local synapse config RAM, one read per cycle.
- For each synapse it emits a {target neuron, signed weight} event to the dendrite/neuron accumulate stage.
- It owns synapse configuration storage, its clear sweep, and an idle indication used for step_done generation.

Parameters:
- SYN_ADDR_W, 12, synapse address width; RAM depth = 2**SYN_ADDR_W.
- NEURON_W, 8, target neuron id width.
- WEIGHT_W, 8, signed synaptic weight width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clear_act  in  1  abort the current walk and flush buffered events.
- clear_config  in  1  level; sweep-clear the synapse RAM while high.
- clear_done  out  1  high once the sweep has written the last address; low when clear_config is low.
- config_addr  in  SYN_ADDR_W  synapse address being configured.
- config_value  in  8  configuration byte.
- config_byte  in  1  0 = weight byte; 1 = target byte (commits the write).
- config_enable  in  1  configuration byte valid.
- syn_start  in  SYN_ADDR_W  first synapse address of the range.
- syn_end  in  SYN_ADDR_W  end address of the range (exclusive).
- syn_vld  in  1  range valid.
- syn_rdy  out  1  range accepted when syn_vld && syn_rdy.
- dend_addr  out  NEURON_W  target neuron.
- dend_weight  out  WEIGHT_W  signed weight.
- dend_vld  out  1  event valid.
- dend_rdy  in  1  downstream ready.
- idle  out  1  no walk active, no read in flight, output buffer empty.

Behaviour:
- Reset: syn_rdy=0, dend_vld=0, clear_done=0, idle=0 while reset is high. The cycle after reset deasserts, idle=1 and syn_rdy=1. RAM contents are not reset.
- RAM entry format: [15:8] weight, [7:0] target. The RAM has one read port (walker) and one write port (config/clear).
- State machine:
  - IDLE -> WALK on a syn_vld && syn_rdy handshake.
  - WALK -> IDLE when the issue pointer reaches syn_end. The last read completes afterward via the pipeline.
  - Any state -> CLEAR while clear_config is high. CLEAR -> IDLE when clear_config falls.
- syn_rdy = (state==IDLE) && !clear_config && !clear_act. Only one range is outstanding at a time.
- Range arithmetic:
  - Count = (syn_end - syn_start) mod 2**SYN_ADDR_W.
  - The pointer increments modulo 2**SYN_ADDR_W, so end<start wraps through the top address.
  - start==end is an empty range: it is accepted, produces no events, and returns to IDLE the next cycle.
- Timing:
  - Handshake at edge N; read of syn_start issued at edge N+1.
  - RAM data valid after edge N+2, captured into the 2-entry output buffer.
  - dend_vld is high after edge N+2 (registered outputs).
  - Sustained throughput is 1 event/cycle while dend_rdy is high.
- Backpressure:
  - A read is issued only if (buffer occupancy + reads in flight) < 2.
  - No event is ever dropped or duplicated.
  - dend_addr/dend_weight stay stable while dend_vld && !dend_rdy.
- Ordering: events are emitted in ascending (modular) address order.
- clear_act:
  - Next edge: go to IDLE, flush the buffer, cancel the in-flight read; dend_vld=0.
  - The RAM is untouched.
  - clear_act has priority over a simultaneous syn_vld.
- clear_config:
  - Sweeps addresses 0..2**SYN_ADDR_W-1, writing 0, one per cycle, starting the cycle after assertion.
  - clear_done rises the cycle after address max is written and holds until clear_config falls.
  - Any walk is aborted as with clear_act.
- Config writes:
  - config_byte=0 latches the weight byte.
  - config_byte=1 writes {latched weight, config_value} to config_addr on the next edge.
  - Ignored while clear_config is high.
  - Allowed during WALK. A read and write to the same address in the same cycle returns old data.
- idle = (state==IDLE) && no read in flight && buffer empty && !clear_config.

Optional Feature:
- SYN_SKIP_ZERO_EN defined:
  - Entries with weight==0 are discarded at buffer capture and produce no dend_vld.
  - They still consume one read cycle.
- Not defined: every synapse in the range is emitted, including zero weights.

Decomposition:
- Package ucaspian_syn_pkg:
  - SYN_ADDR_W, NEURON_W and WEIGHT_W defaults.
  - Packed struct syn_entry_t {logic signed [7:0] weight; logic [7:0] target}.
  - Enum walk_state_t {IDLE, WALK, CLEAR}.
- Sub-module ucaspian_syn_outbuf: 2-entry valid/ready buffer with occupancy output, used for the credit check.
- The RAM is an existing dual-port RAM instance sized 16 x 4096.

Test Plan:
- Config 10..12 = {w=5,t=3},{w=-2,t=7},{w=1,t=0}; range start=10,end=13 with dend_rdy=1 -> events (3,5),(7,-2),(0,1) on consecutive cycles, the first 2 cycles after the handshake; idle returns high.
- Same range, dend_rdy toggling 1,0,0,1,... -> same 3 events in order, outputs stable while stalled, no loss or duplicates.
- Range start=20,end=20 -> zero events; syn_rdy high again 1 cycle after the handshake.
- Range start=4094,end=2 -> 4 events from addresses 4094,4095,0,1 in that order.
- clear_act asserted 2 cycles into a 100-synapse walk -> dend_vld low next cycle, idle high, and a subsequent range works normally.
- clear_config held -> clear_done rises after 4096 writes; walk 0..8 yields 8 events with weight 0 (none with SYN_SKIP_ZERO_EN).
